bf_pair_feeder: RTL

BF_PAIR_FEEDER -- requirements
Module: bf_pair_feeder

---
 rtl/bf_pair_feeder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bf_pair_feeder.sv
// Radix-2 butterfly operand feeder: buffers the first SPAN samples of a frame, then pairs
// each second-half sample with its buffered partner and emits the pair with its twiddle index.
module bf_pair_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int SPAN       = 8,
   parameter int ADDR_WIDTH = $clog2(SPAN)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic                         in_sof,
   input  logic signed [DATA_WIDTH-1:0] in_r,
   input  logic signed [DATA_WIDTH-1:0] in_i,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] xp_r,
   output logic signed [DATA_WIDTH-1:0] xp_i,
   output logic signed [DATA_WIDTH-1:0] xq_r,
   output logic signed [DATA_WIDTH-1:0] xq_i,
   output logic [ADDR_WIDTH-1:0]        twid_addr,
   output logic                         out_sof,
   output logic                         out_eof
);

   typedef enum logic {StFill, StPair} state_e;

   localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(SPAN - 1);

   state_e                  state_q, state_d, eff_state;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d, eff_cnt;
   logic                    out_valid_q, out_valid_d;
   logic                    out_sof_q, out_sof_d;
   logic                    out_eof_q, out_eof_d;
   logic [DATA_WIDTH-1:0]   xp_r_q, xp_r_d, xp_i_q, xp_i_d;
   logic [DATA_WIDTH-1:0]   xq_r_q, xq_r_d, xq_i_q, xq_i_d;
   logic [ADDR_WIDTH-1:0]   twid_q, twid_d;
   logic                    sof_hit, last, wr_en;
   logic [2*DATA_WIDTH-1:0] rd_data;

   // Sample buffer: written only in FILL, read only in PAIR, so no reset is needed.
   logic [2*DATA_WIDTH-1:0] mem_q [SPAN];

   always_comb begin
      // A valid in_sof behaves as if the FSM were already at the start of FILL.
      sof_hit   = in_valid & in_sof;
      eff_state = sof_hit ? StFill : state_q;
      eff_cnt   = sof_hit ? '0 : cnt_q;
      last      = (eff_cnt == LastIdx);
      rd_data   = mem_q[eff_cnt];

      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_en       = 1'b0;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
      xp_r_d      = xp_r_q;
      xp_i_d      = xp_i_q;
      xq_r_d      = xq_r_q;
      xq_i_d      = xq_i_q;
      twid_d      = twid_q;

      if (in_valid) begin
         cnt_d = last ? '0 : eff_cnt + ADDR_WIDTH'(1);
         if (eff_state == StFill) begin
            wr_en   = 1'b1;
            state_d = last ? StPair : StFill;
         end else begin
            state_d     = last ? StFill : StPair;
            out_valid_d = 1'b1;
            out_sof_d   = (eff_cnt == '0);
            out_eof_d   = last;
            xp_r_d      = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
            xp_i_d      = rd_data[DATA_WIDTH-1:0];
            xq_r_d      = in_r;
            xq_i_d      = in_i;
            twid_d      = eff_cnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFill;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         xp_r_q      <= '0;
         xp_i_q      <= '0;
         xq_r_q      <= '0;
         xq_i_q      <= '0;
         twid_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         xp_r_q      <= xp_r_d;
         xp_i_q      <= xp_i_d;
         xq_r_q      <= xq_r_d;
         xq_i_q      <= xq_i_d;
         twid_q      <= twid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[eff_cnt] <= {in_r, in_i};
      end
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign xp_r      = xp_r_q;
   assign xp_i      = xp_i_q;
   assign xq_r      = xq_r_q;
   assign xq_i      = xq_i_q;
   assign twid_addr = twid_q;

endmodule
